// File: rtl/pcs25g_pkg.sv
// pcs25g_pkg: shared widths for the 25G PCS gearbox chain
package pcs25g_pkg;
  localparam int GB_IN_W  = 192;
  localparam int GB_OUT_W = 64;
  localparam int GB_BEATS = 3;
endpackage

// File: rtl/pcs_sync_fifo.sv
// pcs_sync_fifo: single-clock FIFO exposing its head entry combinationally
module pcs_sync_fifo #(
  parameter int WIDTH = 193,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  // storage is not reset; only the pointers define what is valid
  always_ff @(posedge clk)
    if (en && push) mem[wr_ptr] <= wdata;
  // pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/gearbox_192_64.sv
// gearbox_192_64: splits buffered 192-bit words into three 64-bit beats
module gearbox_192_64 import pcs25g_pkg::*; #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_enable,
  output logic                out_idle,
  input  logic [GB_IN_W-1:0]  in_data,
  input  logic                in_datavalid,
  input  logic                in_dataerror,
  output logic [GB_OUT_W-1:0] out_data,
  output logic                out_datavalid,
  output logic                out_dataerror,
  output logic                out_protoerr,
  input  logic                in_idle
);
  logic [GB_IN_W:0] head;
  logic full, empty, push, pop;
  logic [1:0] beat;
  assign out_idle      = in_enable & ~full;
  assign push          = in_datavalid & out_idle;
  assign out_datavalid = in_enable & ~empty & in_idle;
  assign pop           = out_datavalid & (beat == 2'(GB_BEATS - 1));
  assign out_dataerror = head[GB_IN_W] & out_datavalid;
  // beat select; zero whenever no beat is presented
  always_comb
    out_data = !out_datavalid ? '0 :
               beat == 2'd0 ? head[GB_OUT_W-1:0] :
               beat == 2'd1 ? head[2*GB_OUT_W-1:GB_OUT_W] :
               head[3*GB_OUT_W-1:2*GB_OUT_W];
  pcs_sync_fifo #(.WIDTH(GB_IN_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .en(in_enable),
    .push(push),
    .pop(pop),
    .wdata({in_dataerror, in_data}),
    .head(head),
    .full(full),
    .empty(empty)
  );
  // beat position within the head word and sticky handshake-violation flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      beat         <= '0;
      out_protoerr <= 1'b0;
    end else if (in_enable) begin
      if (out_datavalid) beat <= pop ? 2'd0 : beat + 2'd1;
      if (in_datavalid && !out_idle) out_protoerr <= 1'b1;
    end
endmodule

// File: doc/gearbox_192_64.md
GEARBOX_192_64 -- requirements
Module: gearbox_192_64

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of 192-bit word entries buffered (legal 2, 4, 8).
REQ-002 SHALL have port clk, input, 1, single clock for all state.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_enable, input, 1, global enable; low freezes all state.
REQ-005 SHALL have port out_idle, output, 1, ready-to-accept indication to the upstream 256-to-192 gearbox.
REQ-006 SHALL have port in_data, input, 192, upstream word.
REQ-007 SHALL have port in_datavalid, input, 1, upstream word valid.
REQ-008 SHALL have port in_dataerror, input, 1, error flag attached to the upstream word.
REQ-009 SHALL have port out_data, output, 64, downstream beat.
REQ-010 SHALL have port out_datavalid, output, 1, downstream beat valid.
REQ-011 SHALL have port out_dataerror, output, 1, error flag of the current beat.
REQ-012 SHALL have port out_protoerr, output, 1, sticky flag for a handshake violation.
REQ-013 SHALL have port in_idle, input, 1, downstream permission to present a beat.

Function
REQ-014 SHALL compute out_idle = in_enable AND NOT full, where full derives only from registered occupancy.
REQ-015 SHALL write {in_dataerror, in_data} at the FIFO tail when in_enable, in_datavalid and out_idle are all high.
REQ-016 SHALL ignore in_datavalid while out_idle is low, and SHALL set out_protoerr in the following cycle.
REQ-017 SHALL keep a 2-bit beat counter (0,1,2) on the head entry.
REQ-018 SHALL compute out_datavalid = in_enable AND NOT empty AND in_idle, combinationally.
REQ-019 SHALL drive out_data = head[64*beat+63 : 64*beat] when valid (beat 0 = bits 63:0), and 64'h0 otherwise.
REQ-020 SHALL drive out_dataerror = head error AND out_datavalid, repeated on all three beats of a word.
REQ-021 SHALL advance beat on each cycle with out_datavalid high; at beat 2 it SHALL wrap to 0 and pop the head in the same edge.
REQ-022 SHALL hold beat and head unchanged while in_idle is low; a partial word resumes at the held beat.
REQ-023 SHALL allow a push and a pop on the same edge, with occupancy unchanged; at full, out_idle is low regardless of a concurrent pop.
REQ-024 SHALL wrap read and write pointers modulo FIFO_DEPTH, with occupancy width clog2(FIFO_DEPTH)+1.
REQ-025 SHALL update no register, including out_protoerr, while in_enable is low; out_idle and out_datavalid are then low.
REQ-026 SHALL give a latency of one cycle from the accepting edge to first-beat out_datavalid into an empty FIFO with in_idle high.
REQ-027 SHALL sustain one 192-bit word per 3 cycles with in_idle held high.

Reset
REQ-028 SHALL, on reset_n low, asynchronously clear pointers, occupancy, beat and out_protoerr.
REQ-029 SHALL give after reset: out_datavalid=0, out_dataerror=0, out_data=0, out_protoerr=0, out_idle=in_enable.
REQ-030 SHALL discard buffered words and any partial word on reset mid-operation; no stale beat appears after release.

Structure
REQ-031 SHALL take constants GB_IN_W=192, GB_OUT_W=64 and GB_BEATS=3 from shared package pcs25g_pkg.
REQ-032 SHALL implement storage as sub-module pcs_sync_fifo (width 193, depth FIFO_DEPTH, async active-low reset).
REQ-033 SHALL keep the beat counter, output muxing and protoerr logic in gearbox_192_64.

Verification
REQ-034 SHALL cover: one word with in_data = {64'hC, 64'hB, 64'hA}, in_idle=1 -> beats 64'hA, 64'hB, 64'hC on 3 consecutive cycles starting 1 cycle after accept, then out_datavalid=0.
REQ-035 SHALL cover: 3 back-to-back words, FIFO_DEPTH=2 -> out_idle low while 2 words are held, 9 contiguous valid beats, no loss.
REQ-036 SHALL cover: in_idle low for 4 cycles after beat 1 of a word -> no valid during the stall, beats 2 and 3 follow when it rises, out_data=0 while stalled.
REQ-037 SHALL cover: word with in_dataerror=1 between two clean words -> out_dataerror high on exactly its 3 beats.
REQ-038 SHALL cover: in_datavalid asserted with FIFO full -> word dropped, out_protoerr=1 next cycle and sticky until reset.
REQ-039 SHALL cover: reset_n asserted mid-beat 1, then in_enable toggled low for 5 cycles -> all outputs at reset values immediately, and no state change while disabled.
